// File: rtl/fetch_queue_pkg.sv
// Purpose: shared types for the instruction-fetch front end (FSM states, queue entry, NOP).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no request outstanding, waiting for queue room
    REQ     = 2'd1,  // request outstanding, response will be enqueued
    DISCARD = 2'd2   // request outstanding, response will be dropped
  } fetch_state_t;

  // Queue entry layout for the default 32-bit PC configuration.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Purpose: synchronous DEPTH-entry FIFO with flush; head entry presented from registers.
// Latency: enqueued word visible at head the cycle after the enqueue edge.
// Backpressure: none internally; caller never enqueues when full (asserted), deq on empty is ignored.
//
// Ports: clk/rst (sync, active-low), flush (clears everything, beats enq/deq),
//        enq/enq_dat, deq, count/count_next (occupancy now / after this edge),
//        head_vld/head_dat (oldest entry).
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_dat,
  input  logic             deq,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_enq_eff;
  logic             w_deq_eff;

  // Flush wins over both operations; deq only counts when an entry exists.
  assign w_enq_eff = enq && !flush;
  assign w_deq_eff = deq && !flush && (r_count != '0);

  always_comb begin
    count_next = r_count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = r_count + CNT_W'(w_enq_eff) - CNT_W'(w_deq_eff);
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_count <= count_next;
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_enq_eff) r_tail <= r_tail + PTR_W'(1);
        if (w_deq_eff) r_head <= r_head + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst && w_enq_eff) begin
      r_mem[r_tail] <= enq_dat;
    end
  end

  assign count    = r_count;
  assign head_vld = (r_count != '0);
  assign head_dat = r_mem[r_head];

  // Requests are only issued with room available, so a full-queue enqueue is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_enq_eff && !w_deq_eff && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_queue.sv
// Purpose: fetch front end: PC generator, single-outstanding icache request FSM, instruction queue.
// Latency: icache response enqueued at its edge, visible as valid/instr/pc the next cycle.
// Backpressure: fetching pauses (IDLE) while the queue would be full; deq stalls drain it.
//
// Ports: clk, rst (sync, active-low); icache_read/icache_addr out, icache_rdata/icache_resp in;
//        redirect/redirect_pc from EX/MEM; deq from ID; valid/instr/pc/count describe the head.
module fetch_queue
  import fetch_types::*;
#(
  parameter int             XLEN     = 32,
  parameter int             DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h00000060)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         icache_read,
  output logic [XLEN-1:0]              icache_addr,
  input  logic [31:0]                  icache_rdata,
  input  logic                         icache_resp,
  input  logic                         redirect,
  input  logic [XLEN-1:0]              redirect_pc,
  input  logic                         deq,
  output logic                         valid,
  output logic [31:0]                  instr,
  output logic [XLEN-1:0]              pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = XLEN + 32;

  fetch_state_t     r_state;
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_req_addr;
  logic             r_read;

  logic             w_enq;
  logic [CNT_W-1:0] w_count_next;
  logic             w_has_room;
  logic             w_head_vld;
  logic [ENTRY_W-1:0] w_head_dat;
  logic [XLEN-1:0]  w_pc_inc;

  // Only a response that belongs to the current fetch stream gets queued.
  assign w_enq      = (r_state == REQ) && icache_resp && !redirect;
  assign w_has_room = (w_count_next < CNT_W'(DEPTH));
  assign w_pc_inc   = r_fetch_pc + XLEN'(4);

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .enq        (w_enq),
    .enq_dat    ({r_fetch_pc, icache_rdata}),
    .deq        (deq),
    .count      (count),
    .count_next (w_count_next),
    .head_vld   (w_head_vld),
    .head_dat   (w_head_dat)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_read     <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      case (r_state)
        IDLE: begin
          r_state    <= REQ;
          r_req_addr <= redirect_pc;
          r_read     <= 1'b1;
        end
        REQ: begin
          // A response landing now is stale; otherwise the in-flight one must be waited out.
          if (icache_resp) begin
            r_req_addr <= redirect_pc;
          end else begin
            r_state <= DISCARD;
          end
        end
        DISCARD: begin
          // Still waiting on the old response; only the restart target moves.
        end
        default: begin
          r_state <= IDLE;
          r_read  <= 1'b0;
        end
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (w_has_room) begin
            r_state    <= REQ;
            r_req_addr <= r_fetch_pc;
            r_read     <= 1'b1;
          end
        end
        REQ: begin
          if (icache_resp) begin
            r_fetch_pc <= w_pc_inc;
            if (w_has_room) begin
              r_req_addr <= w_pc_inc;
            end else begin
              r_state <= IDLE;
              r_read  <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (icache_resp) begin
            r_state    <= REQ;
            r_req_addr <= r_fetch_pc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_read  <= 1'b0;
        end
      endcase
    end
  end

  assign icache_read = r_read;
  assign icache_addr = r_req_addr;

  assign valid = w_head_vld;
  assign instr = w_head_vld ? w_head_dat[31:0] : NOP_INSTR;
  assign pc    = w_head_vld ? w_head_dat[ENTRY_W-1:32] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Purpose: self-checking bench for fetch_queue with an icache responder and a scoreboard.
// Latency: responder latency programmable per request (lat cycles after read is seen).
// Backpressure: deq driven by each scenario to stall or drain the queue.
module tb_fetch_queue;
  import fetch_types::*;

  localparam logic [31:0] RST_PC = 32'h00000060;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_read;
  logic [31:0] icache_addr;
  logic [31:0] icache_rdata;
  logic        icache_resp;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  // Responder / model state
  int           lat = 1;
  bit           force_stale = 0;
  bit           rsp_active = 0;
  int           rsp_left = 0;
  logic [31:0]  rsp_addr = '0;
  logic [31:0]  req_log[$];
  fetch_entry_t expq[$];
  logic [31:0]  mdl_pc = RST_PC;
  bit           disc = 0;
  bit           chk_en = 0;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .icache_read  (icache_read),
    .icache_addr  (icache_addr),
    .icache_rdata (icache_rdata),
    .icache_resp  (icache_resp),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .deq          (deq),
    .valid        (valid),
    .instr        (instr),
    .pc           (pc),
    .count        (count)
  );

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // icache responder: acts 2 time units after each edge, after the scenario drives at +1.
  initial begin
    icache_resp  = 1'b0;
    icache_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      icache_resp = 1'b0;
      if (!rst) begin
        rsp_active   = 0;
        icache_resp  = force_stale;
        icache_rdata = 32'hBAD0_BAD0;
      end else if (icache_read) begin
        if (!rsp_active) begin
          rsp_active = 1;
          rsp_addr   = icache_addr;
          rsp_left   = lat;
          req_log.push_back(icache_addr);
          if (!disc) begin
            checks++;
            if (icache_addr !== mdl_pc) begin
              errors++;
              $display("FAIL req_addr: got %h expected %h", icache_addr, mdl_pc);
            end
          end
        end else begin
          checks++;
          if (icache_addr !== rsp_addr) begin
            errors++;
            $display("FAIL addr_stable: got %h expected %h", icache_addr, rsp_addr);
          end
        end
        rsp_left--;
        if (rsp_left <= 0) begin
          icache_resp  = 1'b1;
          icache_rdata = fdat(rsp_addr);
          rsp_active   = 0;
        end
      end
    end
  end

  // Reference model, stepped on the same edge the DUT state changes.
  always @(posedge clk) begin
    if (!rst) begin
      expq.delete();
      mdl_pc = RST_PC;
      disc   = 0;
    end else if (redirect) begin
      expq.delete();
      mdl_pc = redirect_pc;
      if (rsp_active && !icache_resp) disc = 1;
    end else begin
      if (deq && expq.size() > 0) void'(expq.pop_front());
      if (icache_resp) begin
        if (disc) begin
          disc = 0;
        end else begin
          expq.push_back('{pc: mdl_pc, instr: fdat(mdl_pc)});
          mdl_pc = mdl_pc + 32'd4;
        end
      end
    end
  end

  // Scoreboard comparison of head and occupancy, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (int'(count) !== expq.size()) begin
        errors++;
        $display("FAIL sb_count: got %0d expected %0d", count, expq.size());
      end
      checks++;
      if (expq.size() > 0) begin
        if (valid !== 1'b1 || pc !== expq[0].pc || instr !== expq[0].instr) begin
          errors++;
          $display("FAIL sb_head: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                   valid, pc, instr, expq[0].pc, expq[0].instr);
        end
      end else begin
        if (valid !== 1'b0 || pc !== 32'h0 || instr !== NOP_INSTR) begin
          errors++;
          $display("FAIL sb_empty: got v=%b pc=%h instr=%h expected v=0 pc=0 instr=%h",
                   valid, pc, instr, NOP_INSTR);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; deq = 1'b0; redirect = 1'b0; redirect_pc = '0;
    lat = 1; force_stale = 0;
    cycle();
    cycle();
    req_log.delete();
    rst = 1'b1;
  endtask

  task automatic wait_read(input string tag);
    int n = 0;
    while (icache_read !== 1'b1 && n < 20) begin cycle(); n++; end
    checks++;
    if (icache_read !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: got read=%b expected 1", tag, icache_read);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (valid !== 1'b1 && n < 40) begin cycle(); n++; end
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: got valid=%b expected 1", tag, valid);
    end
  endtask

  task automatic wait_count(input int c, input string tag);
    int n = 0;
    while (int'(count) != c && n < 40) begin cycle(); n++; end
    checks++;
    if (int'(count) != c) begin
      errors++;
      $display("FAIL %s_timeout: got count=%0d expected %0d", tag, count, c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; deq = 1'b0; redirect = 1'b0; redirect_pc = '0;
    cycle();
    cycle();
    checks++;
    if (icache_read !== 1'b0 || valid !== 1'b0 || count !== 3'd0 ||
        instr !== NOP_INSTR || pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got read=%b v=%b cnt=%0d instr=%h pc=%h expected 0 0 0 %h 0",
               icache_read, valid, count, instr, pc, NOP_INSTR);
    end
    chk_en = 1;
  endtask

  task automatic test_stream();
    do_reset();
    deq = 1'b1;
    wait_read("stream_read");
    checks++;
    if (icache_addr !== RST_PC) begin
      errors++;
      $display("FAIL stream_first_addr: got %h expected %h", icache_addr, RST_PC);
    end
    cycle();
    cycle();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (valid !== 1'b1 || count > 3'd1) begin
        errors++;
        $display("FAIL stream_rate: got v=%b cnt=%0d expected v=1 cnt<=1", valid, count);
      end
      cycle();
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    wait_count(4, "fill");
    cycle();
    cycle();
    checks++;
    if (icache_read !== 1'b0 || count !== 3'd4) begin
      errors++;
      $display("FAIL fill_idle: got read=%b cnt=%0d expected read=0 cnt=4", icache_read, count);
    end
    deq = 1'b1;
    cycle();
    deq = 1'b0;
    checks++;
    if (count !== 3'd3 || icache_read !== 1'b1 || icache_addr !== 32'h70) begin
      errors++;
      $display("FAIL drain_refetch: got cnt=%0d read=%b addr=%h expected cnt=3 read=1 addr=70",
               count, icache_read, icache_addr);
    end
    cycle();
    cycle();
  endtask

  task automatic test_redirect_miss();
    int n = 0;
    do_reset();
    wait_count(2, "miss_fill");
    lat = 5;
    cycle();
    cycle();
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect = 1'b0; lat = 1;
    checks++;
    if (count !== 3'd0 || icache_read !== 1'b1 || icache_addr !== 32'h68) begin
      errors++;
      $display("FAIL miss_flush: got cnt=%0d read=%b addr=%h expected cnt=0 read=1 addr=68",
               count, icache_read, icache_addr);
    end
    while (!(icache_read === 1'b1 && icache_addr === 32'h200) && n < 20) begin cycle(); n++; end
    checks++;
    if (icache_addr !== 32'h200 || count !== 3'd0) begin
      errors++;
      $display("FAIL miss_restart: got addr=%h cnt=%0d expected addr=200 cnt=0", icache_addr, count);
    end
    deq = 1'b1;
    wait_valid("miss_valid");
    checks++;
    if (pc !== 32'h200 || instr !== fdat(32'h200)) begin
      errors++;
      $display("FAIL miss_first_pc: got pc=%h instr=%h expected pc=200 instr=%h",
               pc, instr, fdat(32'h200));
    end
  endtask

  task automatic test_redirect_resp();
    int n = 0;
    do_reset();
    lat = 3;
    @(posedge clk); #3;
    while (icache_resp !== 1'b1 && n < 20) begin @(posedge clk); #3; n++; end
    redirect = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1;
    redirect = 1'b0;
    checks++;
    if (icache_read !== 1'b1 || icache_addr !== 32'h200 || count !== 3'd0) begin
      errors++;
      $display("FAIL coincide_redirect: got read=%b addr=%h cnt=%0d expected read=1 addr=200 cnt=0",
               icache_read, icache_addr, count);
    end
    deq = 1'b1;
    wait_valid("coincide_valid");
    checks++;
    if (pc !== 32'h200) begin
      errors++;
      $display("FAIL coincide_first_pc: got %h expected 200", pc);
    end
  endtask

  task automatic test_double_redirect();
    bit saw200 = 0;
    do_reset();
    lat = 6;
    deq = 1'b1;
    wait_read("double_read");
    cycle();
    cycle();
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect_pc = 32'h300;
    cycle();
    redirect = 1'b0; lat = 1;
    wait_valid("double_valid");
    checks++;
    if (pc !== 32'h300) begin
      errors++;
      $display("FAIL double_first_pc: got %h expected 300", pc);
    end
    foreach (req_log[i]) if (req_log[i] == 32'h200) saw200 = 1;
    checks++;
    if (saw200) begin
      errors++;
      $display("FAIL double_skip: got request to 200 expected none");
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    wait_count(2, "mrst_fill");
    lat = 5;
    cycle();
    cycle();
    rst = 1'b0; force_stale = 1;
    cycle();
    rst = 1'b1; force_stale = 0;
    checks++;
    if (valid !== 1'b0 || count !== 3'd0 || icache_read !== 1'b0) begin
      errors++;
      $display("FAIL mrst_state: got v=%b cnt=%0d read=%b expected 0 0 0", valid, count, icache_read);
    end
    lat = 1;
    wait_read("mrst_read");
    checks++;
    if (icache_addr !== RST_PC) begin
      errors++;
      $display("FAIL mrst_addr: got %h expected %h", icache_addr, RST_PC);
    end
    deq = 1'b1;
    wait_valid("mrst_valid");
    checks++;
    if (pc !== RST_PC) begin
      errors++;
      $display("FAIL mrst_first_pc: got %h expected %h", pc, RST_PC);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_fill_drain();
    test_redirect_miss();
    test_redirect_resp();
    test_double_redirect();
    test_mid_reset();
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
